// File: rtl/i2s_tx.sv
// I2S master transmitter: valid/ready stereo samples in, BCLK/WS/DATA out, single clock domain.
// Define I2S_TX_LEFT_JUSTIFIED_EN for left-justified framing (no one-BCLK data delay).
module i2s_tx #(
    parameter int BCLK_DIV = 4,
    parameter int SAMPLE_W = 16
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic [SAMPLE_W-1:0] s_left,
    input  logic [SAMPLE_W-1:0] s_right,
    input  logic                s_valid,
    output logic                s_ready,
    output logic                i2s_bclk,
    output logic                i2s_ws,
    output logic                i2s_data,
    output logic                underrun
);

    localparam int FRAME_W = 2 * SAMPLE_W;
    localparam int CNT_W   = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int P_W     = $clog2(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BCLK_DIV - 1);
    localparam logic [P_W-1:0]   P_LAST   = P_W'(FRAME_W - 1);
    localparam logic [P_W-1:0]   P_RIGHT  = P_W'(SAMPLE_W);

    logic [1:0]                 rst_sync;
    logic                       rst_n;
    logic [CNT_W-1:0]           cnt_p0;
    logic [P_W-1:0]             p_p0;
    logic [P_W-1:0]             p_nxt;
    logic                       wrap;
    logic                       fall;
    logic                       frame_load;
    logic                       xfer;
    logic                       hold_full;
    logic signed [SAMPLE_W-1:0] hold_l;
    logic signed [SAMPLE_W-1:0] hold_r;
    logic [FRAME_W-1:0]         shreg_p1;
    logic [FRAME_W-1:0]         shreg_nxt;
    logic                       data_nxt;

    // Reset asserts immediately, releases two clocks after reset_n rises
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    always_comb begin
        wrap       = (cnt_p0 == CNT_LAST);
        fall       = wrap & i2s_bclk;
        p_nxt      = (p_p0 == P_LAST) ? '0 : p_p0 + P_W'(1);
        frame_load = fall & (p_p0 == P_LAST);
        s_ready    = ~hold_full | frame_load;
        xfer       = s_valid & s_ready;
        if (frame_load) shreg_nxt = hold_full ? {hold_l, hold_r} : '0;
        else            shreg_nxt = {shreg_p1[FRAME_W-2:0], 1'b0};
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
        data_nxt   = shreg_nxt[FRAME_W-1];
`else
        // Philips mode: the bit for the previous slot goes out now
        data_nxt   = shreg_p1[FRAME_W-1];
`endif
    end

    // Stage p0: bit-clock divider
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            cnt_p0   <= '0;
            i2s_bclk <= 1'b0;
        end else if (wrap) begin
            cnt_p0   <= '0;
            i2s_bclk <= ~i2s_bclk;
        end else begin
            cnt_p0   <= cnt_p0 + CNT_W'(1);
        end
    end

    // Stage p1: slot position, shift pair and serial outputs, all on BCLK falling edge
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            p_p0     <= '0;
            shreg_p1 <= '0;
            i2s_ws   <= 1'b0;
            i2s_data <= 1'b0;
            underrun <= 1'b0;
        end else begin
            underrun <= frame_load & ~hold_full;
            if (fall) begin
                p_p0     <= p_nxt;
                shreg_p1 <= shreg_nxt;
                i2s_ws   <= (p_nxt >= P_RIGHT);
                i2s_data <= data_nxt;
            end
        end
    end

    // A pair offered on the load cycle into an empty hold lands in hold, not in this frame
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            hold_full <= 1'b0;
            hold_l    <= '0;
            hold_r    <= '0;
        end else if (xfer) begin
            hold_full <= 1'b1;
            hold_l    <= s_left;
            hold_r    <= s_right;
        end else if (frame_load) begin
            hold_full <= 1'b0;
        end
    end

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx (BCLK_DIV=2, SAMPLE_W=16); frames captured by a BCLK-edge monitor.
module tb_i2s_tx;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] s_left  = '0;
    logic [15:0] s_right = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        i2s_bclk;
    logic        i2s_ws;
    logic        i2s_data;
    logic        underrun;

    int total = 0;
    int bad   = 0;

`ifdef I2S_TX_LEFT_JUSTIFIED_EN
    localparam int          LATCH_P = 31;
    localparam logic [31:0] WS_EXP  = 32'h0000_FFFF;
`else
    localparam int          LATCH_P = 0;
    localparam logic [31:0] WS_EXP  = 32'h0001_FFFE;
`endif

    i2s_tx #(.BCLK_DIV(2), .SAMPLE_W(16)) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .s_left  (s_left),
        .s_right (s_right),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .i2s_bclk(i2s_bclk),
        .i2s_ws  (i2s_ws),
        .i2s_data(i2s_data),
        .underrun(underrun)
    );

    always #5 clk_sys = ~clk_sys;

    // Monitor: tracks slot position from BCLK falling edges and records each completed frame
    int          p_mon     = 0;
    int          frame_cnt = 0;
    logic        bclk_last = 1'b0;
    logic        ur_last   = 1'b0;
    int          uc_pulses = 0;
    int          uc_cycles = 0;
    logic [31:0] sh_d      = '0;
    logic [31:0] sh_w      = '0;
    logic [31:0] frames [0:63];
    logic [31:0] wsf    [0:63];

    always @(negedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            p_mon     = 0;
            bclk_last = 1'b0;
            ur_last   = 1'b0;
            sh_d      = '0;
            sh_w      = '0;
        end else begin
            if (bclk_last && !i2s_bclk) begin
                p_mon = (p_mon + 1) % 32;
                sh_d  = {sh_d[30:0], i2s_data};
                sh_w  = {sh_w[30:0], i2s_ws};
                if (p_mon == LATCH_P && frame_cnt < 63) begin
                    frame_cnt = frame_cnt + 1;
                    frames[frame_cnt] = sh_d;
                    wsf[frame_cnt]    = sh_w;
                end
            end
            bclk_last = i2s_bclk;
            if (underrun) uc_cycles = uc_cycles + 1;
            if (underrun && !ur_last) uc_pulses = uc_pulses + 1;
            ur_last = underrun;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_frame(input int n);
        int guard = 0;
        while (frame_cnt < n && guard < 2000) begin
            @(posedge clk_sys);
            guard++;
        end
        check("frame_reached", 64'(frame_cnt >= n), 64'd1);
        repeat (16) @(posedge clk_sys);
        #1;
    endtask

    task automatic wait_p(input int target);
        int guard = 0;
        while (p_mon != target && guard < 1000) begin
            @(posedge clk_sys);
            #1;
            guard++;
        end
        check("p_reached", 64'(p_mon), 64'(target));
    endtask

    task automatic push(input logic [15:0] l, input logic [15:0] r);
        int   guard = 0;
        logic done  = 1'b0;
        s_left  = l;
        s_right = r;
        s_valid = 1'b1;
        while (!done && guard < 1000) begin
            @(negedge clk_sys);
            if (s_ready) done = 1'b1;
            @(posedge clk_sys);
            #1;
            guard++;
        end
        s_valid = 1'b0;
        check("push_accepted", 64'(done), 64'd1);
    endtask

    int base;

    initial begin
        // Reset state
        repeat (3) @(posedge clk_sys);
        #1;
        check("rst_bclk",     64'(i2s_bclk), 64'd0);
        check("rst_ws",       64'(i2s_ws),   64'd0);
        check("rst_data",     64'(i2s_data), 64'd0);
        check("rst_ready",    64'(s_ready),  64'd1);
        check("rst_underrun", 64'(underrun), 64'd0);
        reset_n = 1'b1;
        repeat (5) @(posedge clk_sys);
        #1;

        // Test 1 (test 6 when built left-justified): one pair, first frame silent
        push(16'hA5C3, 16'h0F01);
        wait_frame(1);
        check("t1_first_silent", 64'(frames[1]), 64'h0);
        wait_frame(2);
        check("t1_data", 64'(frames[2]), 64'hA5C3_0F01);
        check("t1_ws",   64'(wsf[2]),    64'(WS_EXP));
        check("t1_underrun", 64'(uc_pulses), 64'd1);

        // Test 2: three frames with nothing offered
        wait_frame(3);
        check("t2_f3", 64'(frames[3]), 64'h0);
        wait_frame(4);
        check("t2_f4", 64'(frames[4]), 64'h0);
        wait_frame(5);
        check("t2_f5", 64'(frames[5]), 64'h0);
        check("t2_underrun", 64'(uc_pulses), 64'd4);
        check("t2_pulse_width", 64'(uc_cycles), 64'(uc_pulses));

        // Test 3: back-to-back pairs 1,2,3 with s_valid held high
        push(16'd1, 16'd1);
        @(negedge clk_sys);
        check("t3_ready_low", 64'(s_ready), 64'd0);
        @(posedge clk_sys);
        #1;
        push(16'd2, 16'd2);
        push(16'd3, 16'd3);
        wait_frame(9);
        check("t3_f7", 64'(frames[7]), 64'h0001_0001);
        check("t3_f8", 64'(frames[8]), 64'h0002_0002);
        check("t3_f9", 64'(frames[9]), 64'h0003_0003);
        // only the load after pair 3 drains the hold underruns
        check("t3_underrun", 64'(uc_pulses), 64'd5);

        // Test 4: pair offered exactly on the load cycle with hold empty
        wait_p(30);
        wait_p(31);
        @(posedge clk_sys);
        @(posedge clk_sys);
        #1;
        s_left  = 16'h8001;
        s_right = 16'h7FFE;
        s_valid = 1'b1;
        @(negedge clk_sys);
        check("t4_ready_on_load", 64'(s_ready), 64'd1);
        @(posedge clk_sys);
        #1;
        s_valid = 1'b0;
        wait_frame(11);
        check("t4_silent", 64'(frames[11]), 64'h0);
        check("t4_underrun", 64'(uc_pulses), 64'd6);
        wait_frame(12);
        check("t4_late_pair", 64'(frames[12]), 64'h8001_7FFE);
        check("t4_underrun2", 64'(uc_pulses), 64'd7);

        // Test 5: reset mid-frame with a pair held
        push(16'hDEAD, 16'hBEEF);
        wait_p(20);
        check("t5_ws_before", 64'(i2s_ws), 64'd1);
        reset_n = 1'b0;
        #1;
        check("t5_bclk",     64'(i2s_bclk), 64'd0);
        check("t5_ws",       64'(i2s_ws),   64'd0);
        check("t5_data",     64'(i2s_data), 64'd0);
        check("t5_ready",    64'(s_ready),  64'd1);
        check("t5_underrun", 64'(underrun), 64'd0);
        repeat (3) @(posedge clk_sys);
        #1;
        reset_n = 1'b1;
        base = frame_cnt;
        wait_frame(base + 1);
        check("t5_f1", 64'(frames[base+1]), 64'h0);
        wait_frame(base + 2);
        check("t5_f2", 64'(frames[base+2]), 64'h0);
        wait_frame(base + 3);
        check("t5_f3", 64'(frames[base+3]), 64'h0);
        check("t5_underrun", 64'(uc_pulses), 64'd10);
        check("t5_pulse_width", 64'(uc_cycles), 64'(uc_pulses));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
